psram_burst_arbiter: RTL and testbench

Shares the single PSRAM controller command channel (channel 0, `clk_2` domain) between two burst requesters: the camera-side writer, which drains the camera FIFO into frame memory, and the LCD-side reader, which refills the display FIFO. The block arbitrates round-robin and enforces the controller's minimum command spacing. It sequences each write burst's data beats and counts each read burst's returned beats. It replaces direct FSM-to-controller wiring inside the video controller path.

---
 rtl/psram_burst_arbiter.sv | 130 +++++++++++++
 tb/tb_psram_burst_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/psram_burst_arbiter.sv
// psram_burst_arbiter: round-robin write/read burst arbiter for one PSRAM command channel
module psram_burst_arbiter #(
    parameter int ADDR_WIDTH   = 21,
    parameter int DATA_WIDTH   = 32,
    parameter int BURST_BEATS  = 8,
    parameter int CMD_GAP      = 14,
    parameter int READ_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init_done,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    output logic                  wr_grant,
    input  logic [DATA_WIDTH-1:0] wr_data_in,
    input  logic [3:0]            wr_mask_in,
    output logic                  wr_data_rd,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_grant,
    output logic [DATA_WIDTH-1:0] rd_data_out,
    output logic                  rd_data_out_valid,
    output logic                  rd_done,
    output logic                  mem_cmd,
    output logic                  mem_cmd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic [3:0]            mem_data_mask,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    input  logic                  mem_rd_data_valid,
    output logic                  busy,
    output logic                  error
);
    localparam int BW = $clog2(BURST_BEATS + 1);
    localparam int GW = $clog2(CMD_GAP);
    localparam int TW = $clog2(READ_TIMEOUT + 1);

    typedef enum logic [1:0] {WAIT_INIT, IDLE, WRITE_BURST, READ_WAIT} state_t;

    state_t                state_q, state_d;
    logic [BW-1:0]         beat_q, beat_d;
    logic [GW-1:0]         gap_q, gap_d;
    logic [TW-1:0]         to_q, to_d;
    logic                  last_wr_q, last_wr_d;
    logic                  error_q, error_d;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q, rd_done_q;
    logic                  rd_beat, rd_last, timeout, pick_wr, go;

    assign rd_data_out       = rd_data_q;
    assign rd_data_out_valid = rd_valid_q;
    assign rd_done           = rd_done_q;
    assign error             = error_q;

    // state/counter registers; returned read beats are re-timed by one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= WAIT_INIT;
            beat_q     <= '0;
            gap_q      <= '0;
            to_q       <= '0;
            last_wr_q  <= 1'b0;
            error_q    <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            gap_q      <= gap_d;
            to_q       <= to_d;
            last_wr_q  <= last_wr_d;
            error_q    <= error_d;
            rd_data_q  <= rd_beat ? mem_rd_data : '0;
            rd_valid_q <= rd_beat;
            rd_done_q  <= rd_last;
        end
    end

    // next state, counters and round-robin pick; the gap counter reaches 0 in the issuing cycle
    always_comb begin
        rd_beat   = state_q == READ_WAIT && mem_rd_data_valid;
        rd_last   = rd_beat && beat_q == BW'(BURST_BEATS - 1);
        timeout   = state_q == READ_WAIT && to_q == TW'(READ_TIMEOUT - 1) && !rd_last;
        gap_d     = mem_cmd_en ? GW'(CMD_GAP - 1) : (gap_q != '0 ? gap_q - GW'(1) : gap_q);
        pick_wr   = wr_req && (!rd_req || !last_wr_q);
        go        = state_q == IDLE && gap_d == '0 && (wr_req || rd_req);
        error_d   = error_q || timeout || (mem_rd_data_valid && state_q != READ_WAIT);
        state_d   = state_q;
        beat_d    = beat_q;
        to_d      = to_q;
        last_wr_d = last_wr_q;
        case (state_q)
            WAIT_INIT: state_d = init_done ? IDLE : WAIT_INIT;
            IDLE: if (go) begin
                state_d   = pick_wr ? WRITE_BURST : READ_WAIT;
                last_wr_d = pick_wr;
                beat_d    = '0;
                to_d      = '0;
            end
            WRITE_BURST: begin
                beat_d  = beat_q == BW'(BURST_BEATS - 1) ? '0 : beat_q + BW'(1);
                state_d = beat_q == BW'(BURST_BEATS - 1) ? IDLE : WRITE_BURST;
            end
            READ_WAIT: begin
                to_d   = to_q == TW'(READ_TIMEOUT) ? to_q : to_q + TW'(1);
                beat_d = beat_q + BW'(rd_beat);
                if (rd_last || timeout) begin
                    state_d = IDLE;
                    beat_d  = '0;
                    to_d    = '0;
                end
            end
            default: state_d = WAIT_INIT;
        endcase
    end

    // command strobes and write data path decoded from the current state
    always_comb begin
        wr_grant      = state_q == WRITE_BURST && beat_q == '0;
        rd_grant      = state_q == READ_WAIT && to_q == '0;
        mem_cmd_en    = wr_grant || rd_grant;
        mem_cmd       = wr_grant;
        mem_addr      = wr_grant ? wr_addr : (rd_grant ? rd_addr : '0);
        wr_data_rd    = state_q == WRITE_BURST;
        mem_wr_data   = wr_data_rd ? wr_data_in : '0;
        mem_data_mask = wr_data_rd ? wr_mask_in : '0;
        busy          = state_q == WRITE_BURST || state_q == READ_WAIT;
    end
endmodule

// File: tb/tb_psram_burst_arbiter.sv
// tb_psram_burst_arbiter: scoreboard bench for the PSRAM burst arbiter
module tb_psram_burst_arbiter;
    logic        clk = 0, reset = 1, init_done = 0;
    logic        wr_req = 0, rd_req = 0;
    logic [20:0] wr_addr = 0, rd_addr = 0;
    logic        wr_grant, wr_data_rd, rd_grant, rd_data_out_valid, rd_done;
    logic [31:0] wr_data_in, rd_data_out, mem_wr_data, mem_rd_data = 0;
    logic [3:0]  wr_mask_in, mem_data_mask;
    logic        mem_cmd, mem_cmd_en, mem_rd_data_valid = 0, busy, error;
    logic [20:0] mem_addr;

    logic [31:0] wbase = 0, widx = 0;
    int          cyc = 0, last_cmd = 0, errors = 0, checks = 0, rc = 0;

    typedef struct { logic cmd; logic [20:0] addr; int delta; } cmd_t;
    typedef struct { logic [31:0] d; logic [3:0] m; } wb_t;
    typedef struct { logic [31:0] d; logic done; } rb_t;
    cmd_t cmd_q[$];
    wb_t  wb_q[$];
    rb_t  rb_q[$];

    psram_burst_arbiter dut (
        .clk(clk), .reset(reset), .init_done(init_done),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_grant(wr_grant),
        .wr_data_in(wr_data_in), .wr_mask_in(wr_mask_in), .wr_data_rd(wr_data_rd),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_grant(rd_grant),
        .rd_data_out(rd_data_out), .rd_data_out_valid(rd_data_out_valid), .rd_done(rd_done),
        .mem_cmd(mem_cmd), .mem_cmd_en(mem_cmd_en), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_data_mask(mem_data_mask),
        .mem_rd_data(mem_rd_data), .mem_rd_data_valid(mem_rd_data_valid),
        .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    // first-word-fall-through writer FIFO model
    assign wr_data_in = wbase + widx;
    assign wr_mask_in = widx[3:0];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (wr_data_rd) widx <= widx + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic push_write(input logic [20:0] a, input int n, input int delta);
        cmd_q.push_back('{1'b1, a, delta});
        for (int i = 0; i < n; i++) begin
            logic [31:0] v;
            v = widx + i;
            wb_q.push_back('{wbase + v, v[3:0]});
        end
    endtask

    task automatic wait_grant(input bit wr);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (wr ? wr_grant : rd_grant) begin
                rc = cyc;
                return;
            end
        end
        fail(wr ? "wr_grant_timeout" : "rd_grant_timeout");
    endtask

    // monitor: pops the scoreboard whenever the DUT presents a command or beat
    always @(negedge clk) begin
        if (mem_cmd_en) begin
            if (cmd_q.size() == 0) fail("unexpected_cmd");
            else begin
                cmd_t e;
                e = cmd_q.pop_front();
                chk("cmd_type", mem_cmd, e.cmd);
                chk("cmd_addr", mem_addr, e.addr);
                chk("cmd_grants", {wr_grant, rd_grant}, e.cmd ? 2'b10 : 2'b01);
                if (e.delta != 0) chk("cmd_spacing", cyc - last_cmd, e.delta);
            end
            last_cmd = cyc;
        end
        if (wr_data_rd) begin
            if (wb_q.size() == 0) fail("unexpected_wr_beat");
            else begin
                wb_t w;
                w = wb_q.pop_front();
                chk("wr_data", mem_wr_data, w.d);
                chk("wr_mask", mem_data_mask, w.m);
            end
        end
        if (rd_data_out_valid) begin
            if (rb_q.size() == 0) fail("unexpected_rd_beat");
            else begin
                rb_t r;
                r = rb_q.pop_front();
                chk("rd_data", rd_data_out, r.d);
                chk("rd_done", rd_done, r.done);
            end
        end else if (rd_done) fail("rd_done_without_data");
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int pat[13] = '{1, 0, 1, 1, 0, 0, 1, 1, 0, 1, 1, 0, 1};
        int k;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {wr_grant, wr_data_rd, rd_grant, rd_data_out_valid, rd_done,
                              mem_cmd, mem_cmd_en, busy, error}, 9'd0);
        chk("reset_bus", {mem_addr, mem_wr_data, rd_data_out}, 85'd0);
        reset = 0;
        // initial tie while calibration is pending: nothing may issue
        wr_addr = 21'h000100; rd_addr = 21'h002000; wbase = 32'hA0;
        wr_req = 1; rd_req = 1;
        repeat (6) @(negedge clk);
        chk("wait_init_idle", busy, 1'b0);
        push_write(21'h000100, 8, 0);
        cmd_q.push_back('{1'b0, 21'h002000, 14});
        k = 0;
        for (int i = 0; i < 13; i++) if (pat[i] != 0) begin
            rb_q.push_back('{32'hD0 + k, k == 7});
            k++;
        end
        init_done = 1;
        wait_grant(1);
        wr_req = 0;
        wait_grant(0);
        rd_req = 0;
        // read with gaps in the returned beats
        k = 0;
        for (int i = 0; i < 13; i++) begin
            mem_rd_data_valid = pat[i] != 0;
            mem_rd_data = 32'hD0 + k;
            if (pat[i] != 0) k++;
            @(negedge clk);
        end
        mem_rd_data_valid = 0;
        repeat (3) @(negedge clk);
        chk("read_ok_error", error, 1'b0);
        chk("read_ok_idle", busy, 1'b0);
        // read that returns only five beats
        rd_addr = 21'h003000;
        cmd_q.push_back('{1'b0, 21'h003000, 0});
        for (int i = 0; i < 5; i++) rb_q.push_back('{32'hE0 + i, 1'b0});
        rd_req = 1;
        wait_grant(0);
        rd_req = 0;
        for (int i = 0; i < 5; i++) begin
            mem_rd_data_valid = 1;
            mem_rd_data = 32'hE0 + i;
            @(negedge clk);
        end
        mem_rd_data_valid = 0;
        while (cyc < rc + 63) @(negedge clk);
        chk("timeout_pending_error", error, 1'b0);
        chk("timeout_pending_busy", busy, 1'b1);
        @(negedge clk);
        chk("timeout_error", error, 1'b1);
        chk("timeout_idle", busy, 1'b0);
        // arbitration resumes; the write is then cut by reset at beat 3
        wr_addr = 21'h000400; wbase = 32'hB0;
        push_write(21'h000400, 4, 0);
        wr_req = 1;
        wait_grant(1);
        wr_req = 0;
        repeat (3) @(negedge clk);
        reset = 1; init_done = 0;
        @(negedge clk);
        chk("reset_abort_rd", wr_data_rd, 1'b0);
        chk("reset_abort_cmd", mem_cmd_en, 1'b0);
        chk("reset_abort_busy_err", {busy, error}, 2'b00);
        reset = 0;
        wr_addr = 21'h000500; wbase = 32'hC0;
        wr_req = 1;
        repeat (5) @(negedge clk);
        chk("reinit_wait", busy, 1'b0);
        push_write(21'h000500, 8, 0);
        init_done = 1;
        wait_grant(1);
        wr_req = 0;
        repeat (12) @(negedge clk);
        chk("pre_stray_error", error, 1'b0);
        // stray returned beat while idle
        mem_rd_data_valid = 1; mem_rd_data = 32'hFF;
        @(negedge clk);
        mem_rd_data_valid = 0;
        @(negedge clk);
        chk("stray_error", error, 1'b1);
        repeat (5) @(negedge clk);
        chk("stray_sticky", error, 1'b1);
        chk("cmd_leftover", cmd_q.size(), 0);
        chk("wr_leftover", wb_q.size(), 0);
        chk("rd_leftover", rb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
